// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one byte to a keyboard/mouse using the host-to-device frame:
// inhibit the clock line, request-to-send by pulling data low, then
// release the clock and let the device clock out 8 data bits (LSB first),
// odd parity and a stop bit. The device then acknowledges by holding data
// low on the 11th clock. Only open-drain pull-low enables are produced;
// the top level turns them into tristate pad drivers.
//
// Ports:
//   clk                clock
//   reset              asynchronous active-low reset
//   send_cmd           one-cycle request, honoured only when idle
//   cmd_byte           byte to send, captured with send_cmd
//   ps2_clk_i          raw PS2_CLK line level (asynchronous)
//   ps2_dat_i          raw PS2_DAT line level (asynchronous)
//   ps2_clk_drive_low  1 = pull PS2_CLK low
//   ps2_dat_drive_low  1 = pull PS2_DAT low
//   busy               high from the cycle after acceptance until idle again
//   cmd_sent           one-cycle pulse, frame acknowledged by device
//   cmd_error          one-cycle pulse, timeout or missing acknowledge
module ps2_host_tx #(
    parameter int unsigned CLK_HOLD      = 5000,
    parameter int unsigned START_TIMEOUT = 750000,
    parameter int unsigned BIT_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_cmd,
    input  logic [7:0] cmd_byte,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       busy,
    output logic       cmd_sent,
    output logic       cmd_error
);

    localparam logic [19:0] HOLD_LAST  = 20'(CLK_HOLD - 1);
    localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] BIT_LAST   = 20'(BIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, WAIT_IDLE, DONE, ERR
    } state_t;

    state_t      state, state_n;
    logic [19:0] cnt, cnt_n;
    logic [3:0]  nbit, nbit_n;     // device falling edges seen so far
    logic [7:0]  shift, shift_n;
    logic        parity, parity_n;
    logic        dat_low_n;
    logic        clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic        fe;
    logic [19:0] limit_last;

    assign fe = clk_prev & ~clk_s2;
    // The first device edge may take much longer than later ones.
    assign limit_last = (nbit == 4'd0) ? START_LAST : BIT_LAST;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        nbit_n    = nbit;
        shift_n   = shift;
        parity_n  = parity;
        dat_low_n = ps2_dat_drive_low;
        unique case (state)
            IDLE: begin
                if (send_cmd) begin
                    shift_n  = cmd_byte;
                    parity_n = ~^cmd_byte;
                    nbit_n   = 4'd0;
                    cnt_n    = 20'd0;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = 20'd0;
                    state_n = RTS;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            RTS: begin
                cnt_n   = 20'd0;
                state_n = SEND;
            end
            SEND: begin
                if (fe) begin
                    cnt_n  = 20'd0;
                    nbit_n = nbit + 4'd1;
                    if (nbit < 4'd8) begin
                        dat_low_n = ~shift[0];
                        shift_n   = {1'b0, shift[7:1]};
                    end else if (nbit == 4'd8) begin
                        dat_low_n = ~parity;
                    end else if (nbit == 4'd9) begin
                        dat_low_n = 1'b0;           // stop bit: release data
                    end else begin
                        // 11th edge: device must be holding data low as ACK
                        state_n = dat_s2 ? ERR : WAIT_IDLE;
                    end
                end else if (cnt == limit_last) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && dat_s2) begin
                    state_n = DONE;
                end else if (cnt == BIT_LAST) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + 20'd1;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Data is only ever pulled low for the start bit and data/parity bits.
        if (state_n == RTS) begin
            dat_low_n = 1'b1;
        end else if (state_n != SEND) begin
            dat_low_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            cnt               <= 20'd0;
            nbit              <= 4'd0;
            shift             <= 8'd0;
            parity            <= 1'b0;
            clk_s1            <= 1'b1;
            clk_s2            <= 1'b1;
            clk_prev          <= 1'b1;
            dat_s1            <= 1'b1;
            dat_s2            <= 1'b1;
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            busy              <= 1'b0;
            cmd_sent          <= 1'b0;
            cmd_error         <= 1'b0;
        end else begin
            clk_s1            <= ps2_clk_i;
            clk_s2            <= clk_s1;
            clk_prev          <= clk_s2;
            dat_s1            <= ps2_dat_i;
            dat_s2            <= dat_s1;
            state             <= state_n;
            cnt               <= cnt_n;
            nbit              <= nbit_n;
            shift             <= shift_n;
            parity            <= parity_n;
            // Outputs decoded from the next state so they line up with it.
            ps2_clk_drive_low <= (state_n == INHIBIT) || (state_n == RTS);
            ps2_dat_drive_low <= dat_low_n;
            busy              <= (state_n != IDLE);
            cmd_sent          <= (state_n == DONE);
            cmd_error         <= (state_n == ERR);
        end
    end

endmodule
